// File: rtl/digitube_pkg.sv
// digitube_pkg: shared constants and display-word layout for the four-digit tube driver
//   digi_t     : {an[3:0], dp, seg[6:0]} matching digi_out bit order
//   HEX_SEG    : hex nibble -> active-low CG..CA pattern
//   AN_ONEHOT  : digit select -> active-high one-hot anode
//   SEG_OFF    : all segments dark
//   DIGI_OFF   : whole display dark, no anode driven
package digitube_pkg;
  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [6:0] seg;
  } digi_t;
  localparam logic [6:0]       SEG_OFF   = 7'h7F;
  localparam logic [11:0]      DIGI_OFF  = 12'h0FF;
  localparam logic [3:0][3:0]  AN_ONEHOT = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  localparam logic [15:0][6:0] HEX_SEG   = {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
                                            7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
endpackage

// File: rtl/hex7seg.sv
// hex7seg: combinational hex nibble to active-low seven-segment decode
//   i_hex : 4-bit hex digit
//   o_seg : {CG,CF,CE,CD,CC,CB,CA}, active-low
module hex7seg
  import digitube_pkg::*;
(
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);
  assign o_seg = HEX_SEG[i_hex];
endmodule

// File: rtl/digitube_driver.sv
// digitube_driver: time-multiplexed four-digit seven-segment display scanner
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   data_in    : four hex digits, digit i = data_in[4i+3:4i]
//   dp_in      : per-digit decimal point, active-high
//   blank_in   : per-digit blank, active-high
//   load       : latch data_in/dp_in/blank_in into shadow registers
//   enable     : scan enable; when low the display is dark and the scan freezes
//   digi_out   : {AN3..AN0, DP, CG..CA}, anodes active-high, DP/segments active-low
//   digit_tick : one-cycle pulse on each digit advance
module digitube_driver
  import digitube_pkg::*;
#(
  parameter int SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] data_in,
  input  logic [3:0]  dp_in,
  input  logic [3:0]  blank_in,
  input  logic        load,
  input  logic        enable,
  output logic [11:0] digi_out,
  output logic        digit_tick
);
  localparam int            CW      = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);
  logic [CW-1:0] r_cnt;
  logic [1:0]    r_sel;
  logic [15:0]   r_data;
  logic [3:0]    r_dp;
  logic [3:0]    r_blank;
  logic          r_tick;
  digi_t         r_digi;
  logic          w_wrap;
  logic [3:0]    w_hex;
  logic [6:0]    w_seg;
  digi_t         w_digi;
  assign w_wrap = enable && r_cnt == CNT_MAX;
  assign w_hex  = r_data[{r_sel, 2'b00} +: 4];
  hex7seg u_hex7seg (
    .i_hex(w_hex),
    .o_seg(w_seg)
  );
  // A blanked digit keeps its anode lit so every slot has the same duty cycle.
  assign w_digi = {AN_ONEHOT[r_sel], r_blank[r_sel] | ~r_dp[r_sel], r_blank[r_sel] ? SEG_OFF : w_seg};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_sel   <= '0;
      r_data  <= '0;
      r_dp    <= '0;
      r_blank <= '0;
      r_tick  <= 1'b0;
      r_digi  <= DIGI_OFF;
    end else begin
      if (load) begin
        r_data  <= data_in;
        r_dp    <= dp_in;
        r_blank <= blank_in;
      end
      if (enable) r_cnt <= w_wrap ? '0 : r_cnt + CW'(1);
      if (w_wrap) r_sel <= r_sel + 2'd1;
      r_tick <= w_wrap;
      r_digi <= enable ? w_digi : DIGI_OFF;
    end
  end
  assign digi_out   = r_digi;
  assign digit_tick = r_tick;
endmodule

// File: tb/tb_digitube_driver.sv
// tb_digitube_driver: scoreboard bench for digitube_driver with SCAN_DIV=4
module tb_digitube_driver;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;
  logic        load = 1'b0;
  logic        enable = 1'b0;
  logic [11:0] digi_out;
  logic        digit_tick;
  int n_tests = 0;
  int n_fail = 0;
  int m_cnt, m_sel;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_blank;
  logic [12:0] exp_q [$];
  logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  digitube_driver #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .dp_in(dp_in), .blank_in(blank_in),
    .load(load), .enable(enable), .digi_out(digi_out), .digit_tick(digit_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [11:0] act, input logic [11:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    m_sel = 0;
    m_data = '0;
    m_dp = '0;
    m_blank = '0;
    exp_q.delete();
  endtask

  // Push the expectation for the coming edge from pre-edge state and inputs, then pop and compare 1 time unit later.
  task automatic tick_cycle();
    logic [11:0] e_digi;
    logic [3:0]  an;
    logic [12:0] e;
    @(posedge clk);
    an = 4'b0001 << m_sel;
    if (!enable) e_digi = 12'h0FF;
    else if (m_blank[m_sel]) e_digi = {an, 8'hFF};
    else e_digi = {an, ~m_dp[m_sel], seg_tab[m_data[4*m_sel +: 4]]};
    exp_q.push_back({enable && m_cnt == 3, e_digi});
    if (load) begin
      m_data = data_in;
      m_dp = dp_in;
      m_blank = blank_in;
    end
    if (enable) begin
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_sel = (m_sel + 1) % 4;
      end else m_cnt++;
    end
    #1;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty: got no entry expected one");
    end else begin
      e = exp_q.pop_front();
      check("sb_digi", digi_out, e[11:0]);
      check("sb_tick", {11'b0, digit_tick}, {11'b0, e[12]});
    end
  endtask

  task automatic goto_slot(input int s);
    for (int i = 0; i < 20; i++) begin
      tick_cycle();
      if (digit_tick && m_sel == s) return;
    end
    n_tests++;
    n_fail++;
    $display("FAIL goto_slot: got no advance expected advance to digit %0d", s);
  endtask

  task automatic check_slots(input string tag, input logic [3:0][11:0] e);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 4; c++) begin
        tick_cycle();
        check(tag, digi_out, e[s]);
        check({tag, "_tick"}, {11'b0, digit_tick}, {11'b0, c == 3});
      end
  endtask

  initial begin
    logic [3:0][11:0] t1234;
    t1234 = {12'h8F9, 12'h4A4, 12'h2B0, 12'h199};
    model_reset();
    #12;
    check("rst_digi", digi_out, 12'h0FF);
    check("rst_tick", {11'b0, digit_tick}, 12'h000);
    reset = 1'b0;
    enable = 1'b1;
    load = 1'b1;
    data_in = 16'h1234;
    for (int k = 1; k <= 20; k++) begin
      tick_cycle();
      load = 1'b0;
      check("scan1234", digi_out, k == 1 ? 12'h1C0 : t1234[((k - 1) / 4) % 4]);
      check("scan1234_tick", {11'b0, digit_tick}, {11'b0, k % 4 == 0});
    end
    data_in = 16'h8888;
    dp_in = 4'b0001;
    load = 1'b1;
    tick_cycle();
    load = 1'b0;
    goto_slot(0);
    check_slots("dp8888", {12'h880, 12'h480, 12'h280, 12'h100});
    data_in = 16'h1234;
    dp_in = 4'b0000;
    blank_in = 4'b1000;
    load = 1'b1;
    tick_cycle();
    load = 1'b0;
    goto_slot(0);
    check_slots("blank3", {12'h8FF, 12'h4A4, 12'h2B0, 12'h199});
    blank_in = 4'b0000;
    load = 1'b1;
    tick_cycle();
    load = 1'b0;
    goto_slot(2);
    tick_cycle();
    check("en_pre", digi_out, 12'h4A4);
    enable = 1'b0;
    data_in = 16'h5234;
    load = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick_cycle();
      load = 1'b0;
      check("en_off", digi_out, 12'h0FF);
      check("en_off_tick", {11'b0, digit_tick}, 12'h000);
    end
    enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_cycle();
      check("en_resume", digi_out, 12'h4A4);
      check("en_resume_tick", {11'b0, digit_tick}, {11'b0, i == 2});
    end
    tick_cycle();
    check("en_load_d3", digi_out, 12'h892);
    goto_slot(0);
    for (int i = 0; i < 3; i++) tick_cycle();
    data_in = 16'hFFFF;
    load = 1'b1;
    tick_cycle();
    load = 1'b0;
    check("adv_load_old", digi_out, 12'h199);
    check("adv_load_tick", {11'b0, digit_tick}, 12'h001);
    for (int i = 0; i < 4; i++) begin
      tick_cycle();
      check("adv_load_d1", digi_out, 12'h28E);
    end
    tick_cycle();
    tick_cycle();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_digi", digi_out, 12'h0FF);
    check("async_rst_tick", {11'b0, digit_tick}, 12'h000);
    model_reset();
    #1;
    reset = 1'b0;
    tick_cycle();
    check("post_rst_d0", digi_out, 12'h1C0);
    for (int i = 0; i < 8; i++) tick_cycle();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
